// File: rtl/l3l4cs_pkg.sv
// Shared types for the l3l4cs checksum-result path: result codes, the queued
// status word layout, statistics counter indices and the drop rule.
package l3l4cs_pkg;

    typedef enum logic [1:0] {
        NOT_CHECKED = 2'b00,
        GOOD        = 2'b01,
        BAD         = 2'b10,
        RSVD        = 2'b11
    } cs_code_e;

    // Field order matches st_data_o: {l4, l3, l2_error, length_error}.
    typedef struct packed {
        cs_code_e l4;
        cs_code_e l3;
        logic     l2_error;
        logic     length_error;
    } cs_status_t;

    localparam int CNT_TOTAL   = 0;
    localparam int CNT_GOOD    = 1;
    localparam int CNT_L3_BAD  = 2;
    localparam int CNT_L4_BAD  = 3;
    localparam int CNT_L2_ERR  = 4;
    localparam int CNT_LEN_ERR = 5;
    localparam int CNT_OVF     = 6;
    localparam int NUM_CNT     = 7;

    function automatic logic code_bad(cs_code_e c);
        return (c == BAD) || (c == RSVD);
    endfunction

    function automatic logic is_error(cs_status_t s);
        return s.l2_error | s.length_error | code_bad(s.l3) | code_bad(s.l4);
    endfunction

endpackage

// File: rtl/l3l4cs_sat_cnt.sv
// Saturating up-counter; a clear takes priority over a same-cycle increment.
module l3l4cs_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/l3l4cs_cs_status_q.sv
// Checksum-result queue: buffers each result strobe, presents it downstream
// with a drop flag, and keeps saturating per-class statistics.
module l3l4cs_cs_status_q
    import l3l4cs_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_WD = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     checksum_valid_i,
    input  logic [1:0]               l3_checksum_i,
    input  logic [1:0]               l4_checksum_i,
    input  logic                     l2_error_i,
    input  logic                     length_error_i,
    output logic                     st_valid_o,
    input  logic                     st_ready_i,
    output logic [5:0]               st_data_o,
    output logic                     st_drop_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic [2:0]               cnt_sel_i,
    input  logic                     cnt_clr_i,
    output logic [CNT_WD-1:0]        cnt_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    cs_status_t   mem [DEPTH];
    cs_status_t   in_status, head;
    logic         empty, full, pop, push_ok, ovf_drop;

    assign in_status = '{l4: cs_code_e'(l4_checksum_i), l3: cs_code_e'(l3_checksum_i),
                         l2_error: l2_error_i, length_error: length_error_i};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Handshake: an entry transfers on a cycle where st_valid_o & st_ready_i;
    // while st_valid_o is high the head (data and drop) never changes until it
    // transfers. A full queue still accepts a push in a cycle that also pops.
    assign pop      = ~empty & st_ready_i;
    assign push_ok  = checksum_valid_i & (~full | pop);
    assign ovf_drop = checksum_valid_i & full & ~pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level_o <= level_o + 1'b1;
            else if (!push_ok && pop) level_o <= level_o - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= in_status;
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign st_valid_o = ~empty;
    assign st_data_o  = st_valid_o ? head : '0;
    assign st_drop_o  = st_valid_o & is_error(head);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       overflow_o <= 1'b0;
        else if (cnt_clr_i) overflow_o <= 1'b0;
        else if (ovf_drop)  overflow_o <= 1'b1;
    end

    // Statistics count every strobe, including results lost to overflow.
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_WD-1:0]  cnt_val [NUM_CNT];

    always_comb begin
        cnt_inc              = '0;
        cnt_inc[CNT_TOTAL]   = checksum_valid_i;
        cnt_inc[CNT_GOOD]    = checksum_valid_i & ~is_error(in_status);
        cnt_inc[CNT_L3_BAD]  = checksum_valid_i & code_bad(in_status.l3);
        cnt_inc[CNT_L4_BAD]  = checksum_valid_i & code_bad(in_status.l4);
        cnt_inc[CNT_L2_ERR]  = checksum_valid_i & l2_error_i;
        cnt_inc[CNT_LEN_ERR] = checksum_valid_i & length_error_i;
        cnt_inc[CNT_OVF]     = ovf_drop;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        l3l4cs_sat_cnt #(.W(CNT_WD)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (cnt_inc[i]),
            .clr     (cnt_clr_i),
            .cnt     (cnt_val[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 cnt_o <= '0;
        else if (cnt_sel_i == 3'd7)   cnt_o <= '0;
        else                          cnt_o <= cnt_val[cnt_sel_i];
    end

endmodule
